enemy_column_ctrl: RTL and testbench
====================================

# enemy_column_ctrl

Parametrised controller for one column of invaders. It tracks a configurable number of rows and the alive state of each, marches the column on frame ticks under swarm direction/drop commands, and resolves player-bullet hits against live rows. It elects the lowest live ship as shooter, paces enemy fire with a frame-count cooldown behind a valid/ready handshake, and reports landed/all-dead status to the swarm controller.

## Interface
- `rows_p`, 5, ships in column (1..16)
- `left_start_p`, 9, reset x of column left edge
- `top_start_p`, 9, reset y of row 0 top edge
- `row_pitch_p`, 40, y distance between row tops
- `ship_w_p` / `ship_h_p`, 24 / 16, ship bounding box
- `step_p`, 2, x pixels per march frame
- `drop_p`, 8, y pixels per drop
- `fire_delay_p`, 60, frames between shots (>=1)
- `land_y_p`, 440, y at which a ship bottom counts as landed
- `x_max_p`, 639, rightmost legal pixel
- `clk_i` in 1: clock
- `reset_ni` in 1: synchronous, active-low reset
- `frame_i` in 1: one-cycle pulse per video frame
- `dir_right_i` in 1: march direction (1 = right)
- `drop_i` in 1: one-cycle request to descend at next frame
- `bullet_v_i` in 1: player bullet position valid this cycle
- `bullet_x_i`, `bullet_y_i` in 10: player bullet tip
- `hit_o` out 1: one-cycle pulse, bullet consumed
- `fire_v_o` out 1: shot request
- `fire_ready_i` in 1: shot accepted
- `fire_x_o`, `fire_y_o` out 10: shot origin (shooter centre-x, bottom-y)
- `alive_o` out rows_p: per-row alive
- `left_pos_o`, `right_pos_o`, `bot_pos_o` out 10: live geometry
- `edge_o` out 1: next step in current direction would leave [0, x_max_p]
- `landed_o` out 1: sticky
- `all_dead_o` out 1

## Operation
- Reset: `alive_o` all ones; x = `left_start_p`; y-offset = 0; cooldown = 0; state COOL; all pulses/valids 0.
- Geometry:
  - `right_pos_o` = x + `ship_w_p` - 1.
  - Row i top = `top_start_p` + i·`row_pitch_p` + y-offset.
  - `bot_pos_o` = bottom of highest-index alive row (0 if all dead).
- Hit:
  - When `bullet_v_i` falls inside the box of an alive row (inclusive bounds), clear that row and pulse `hit_o` the next cycle.
  - Rows do not overlap, so at most one row is hit. Dead rows are transparent.
- Movement (on `frame_i`, when not all dead and not landed):
  - A pending drop (latched from `drop_i`) adds `drop_p` to y-offset and clears.
  - Otherwise x ± `step_p` per `dir_right_i`.
  - x never wraps: if `edge_o` is set, x holds and the swarm must issue `drop_i`.
- Shooter: highest-index alive row. The index feeds `fire_x_o` = x + `ship_w_p`/2 and `fire_y_o` = that row's bottom + 1.
- FSM:
  - COOL: cooldown++ on `frame_i`. At `fire_delay_p`-1 go to FIRE and clear cooldown.
  - FIRE: `fire_v_o`=1 with stable coords. On `fire_ready_i` go to COOL.
  - DEAD: entered from any state when `all_dead_o`. Absorbing until reset.
  - LANDED: entered when `bot_pos_o` >= `land_y_p`. Absorbing until reset. `landed_o`=1.
- Simultaneous events:
  - A hit on the shooter while in FIRE: coords update to the new shooter the next cycle. Accepted shots are not retracted.
  - Last ship killed while `fire_v_o` is set: `fire_v_o` drops with DEAD. This is the only withdrawal allowed.
  - `drop_i` coincident with `frame_i`: drop is applied this frame.
  - Hit and `frame_i` in the same cycle: the hit is tested against pre-move geometry.
  - LANDED takes priority over DEAD if both arise in the same cycle.

## Timing
- All outputs registered.
- `hit_o`, `alive_o`, `all_dead_o`: 1 cycle after the qualifying `bullet_v_i`.
- Position outputs update 1 cycle after `frame_i`. `edge_o` and `landed_o` follow combinationally from the registered position, the same cycle the position updates.
- `fire_v_o` rises 1 cycle after the terminal `frame_i`. The handshake completes in the cycle where `fire_v_o` and `fire_ready_i` are both high. The next request comes no earlier than `fire_delay_p` frames later.
- `reset_ni` low mid-operation (including FIRE): the next edge restores all reset values. No pending shot survives.

## Structure
- Shared `enemy_pkg` holds:
  - the `enemy_col_state_e` enum (COOL, FIRE, DEAD, LANDED);
  - screen constants (`SCREEN_W`, `SCREEN_H`);
  - the 10-bit `coord_t` typedef.
- Sub-module `enemy_lowest_alive`: a parametrised priority encoder (rows_p -> index plus any-alive). It is reused by the swarm for column selection.

## Test plan
- Reset defaults (rows_p=5): release reset, no stimulus.
  - `alive_o`=5'b11111, `left_pos_o`=9, `right_pos_o`=32, `bot_pos_o`=184, `fire_v_o`=0.
- March: 10 `frame_i` with `dir_right_i`=1 -> `left_pos_o`=29. Then `drop_i` + `frame_i` -> `bot_pos_o`=192 and x unchanged.
- Hit row 4 (bullet at x=20, y=180): `hit_o` pulses once, `alive_o`=5'b01111, `bot_pos_o`=144, `fire_y_o`=145. A bullet at row 4's old box later gives no hit.
- Fire handshake with `fire_delay_p`=3: after 3 frames `fire_v_o`=1. Hold `fire_ready_i`=0 for 20 cycles -> coords stable. Ready for 1 cycle -> COOL, and the next request comes exactly 3 frames later.
- Kill all 5 rows while in FIRE: `fire_v_o` drops with `all_dead_o`=1. Further frames do not move x.
- Landing: repeated drops until `bot_pos_o` >= 440 -> `landed_o`=1 and movement stops. Assert `reset_ni`=0 for 1 cycle -> all reset values restored.

Source files
------------

// File: rtl/enemy_pkg.sv
// enemy_pkg
// Shared types and constants for the invader swarm blocks.
//   enemy_col_state_e : per-column fire/lifecycle state
//   SCREEN_W/SCREEN_H : visible raster size in pixels
//   coord_t           : 10-bit screen coordinate
package enemy_pkg;

    typedef enum logic [1:0] {
        COOL   = 2'd0,
        FIRE   = 2'd1,
        DEAD   = 2'd2,
        LANDED = 2'd3
    } enemy_col_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/enemy_lowest_alive.sv
// enemy_lowest_alive
// Priority encoder that picks the highest-index set bit, i.e. the ship that
// sits lowest on screen. Also used by the swarm to pick a shooting column.
// Ports:
//   alive_i : one bit per slot, 1 = alive
//   idx_o   : index of the highest set bit (0 when none set)
//   any_o   : at least one bit set
module enemy_lowest_alive
    import enemy_pkg::*;
#(
    parameter int rows_p  = 5,
    parameter int idx_w_p = (rows_p > 1) ? $clog2(rows_p) : 1
) (
    input  logic [rows_p-1:0]  alive_i,
    output logic [idx_w_p-1:0] idx_o,
    output logic               any_o
);

    // Later iterations overwrite earlier ones, so the highest live index wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < rows_p; i++) begin
            if (alive_i[i]) begin
                idx_o = idx_w_p'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_column_ctrl.sv
// enemy_column_ctrl
// Controller for one column of invaders: alive tracking, frame-driven march
// and drop, bullet hit resolution, shooter election and paced enemy fire.
// Ports:
//   clk_i, reset_ni            : clock, synchronous active-low reset
//   frame_i                    : one-cycle pulse per video frame
//   dir_right_i, drop_i        : swarm march direction / descend request
//   bullet_v_i/x_i/y_i         : player bullet tip
//   hit_o                      : one-cycle pulse, bullet consumed
//   fire_v_o/fire_ready_i      : shot request handshake
//   fire_x_o, fire_y_o         : shot origin (shooter centre-x, bottom+1)
//   alive_o                    : per-row alive bits
//   left/right/bot_pos_o       : live column geometry
//   edge_o, landed_o, all_dead_o : status for the swarm controller
module enemy_column_ctrl
    import enemy_pkg::*;
#(
    parameter int rows_p       = 5,
    parameter int left_start_p = 9,
    parameter int top_start_p  = 9,
    parameter int row_pitch_p  = 40,
    parameter int ship_w_p     = 24,
    parameter int ship_h_p     = 16,
    parameter int step_p       = 2,
    parameter int drop_p       = 8,
    parameter int fire_delay_p = 60,
    parameter int land_y_p     = 440,
    parameter int x_max_p      = SCREEN_W - 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              frame_i,
    input  logic              dir_right_i,
    input  logic              drop_i,
    input  logic              bullet_v_i,
    input  logic [9:0]        bullet_x_i,
    input  logic [9:0]        bullet_y_i,
    output logic              hit_o,
    output logic              fire_v_o,
    input  logic              fire_ready_i,
    output logic [9:0]        fire_x_o,
    output logic [9:0]        fire_y_o,
    output logic [rows_p-1:0] alive_o,
    output logic [9:0]        left_pos_o,
    output logic [9:0]        right_pos_o,
    output logic [9:0]        bot_pos_o,
    output logic              edge_o,
    output logic              landed_o,
    output logic              all_dead_o
);

    localparam int idx_w_p  = (rows_p > 1) ? $clog2(rows_p) : 1;
    localparam int cool_w_p = (fire_delay_p > 1) ? $clog2(fire_delay_p) : 1;

    function automatic int row_top(input int idx, input coord_t yoff);
        return top_start_p + idx * row_pitch_p + int'(yoff);
    endfunction

    function automatic coord_t row_bottom(input logic [idx_w_p-1:0] idx, input coord_t yoff);
        return coord_t'(row_top(int'(idx), yoff) + ship_h_p - 1);
    endfunction

    enemy_col_state_e    state_q, state_d;
    coord_t              x_q, x_d;
    coord_t              yoff_q, yoff_d;
    coord_t              fire_x_q, fire_x_d;
    coord_t              fire_y_q, fire_y_d;
    logic [rows_p-1:0]   alive_q, alive_d;
    logic [cool_w_p-1:0] cool_q, cool_d;
    logic                drop_pend_q, drop_pend_d;
    logic                hit_q, hit_d;

    logic [rows_p-1:0]   hit_vec;
    logic [idx_w_p-1:0]  cur_idx, nxt_idx;
    logic                cur_any, nxt_any;
    logic                edge_w;
    logic                moving;
    logic                land_d;

    // Shooter for the current alive set drives bot_pos_o; the one for the
    // next alive set lets fire coords and DEAD entry line up with alive_o.
    enemy_lowest_alive #(.rows_p(rows_p), .idx_w_p(idx_w_p)) u_cur (
        .alive_i (alive_q),
        .idx_o   (cur_idx),
        .any_o   (cur_any)
    );

    enemy_lowest_alive #(.rows_p(rows_p), .idx_w_p(idx_w_p)) u_nxt (
        .alive_i (alive_d),
        .idx_o   (nxt_idx),
        .any_o   (nxt_any)
    );

    // Hits are resolved against the registered (pre-move) geometry.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < rows_p; i++) begin
            if (bullet_v_i && alive_q[i]
                && int'(bullet_x_i) >= int'(x_q)
                && int'(bullet_x_i) <= int'(x_q) + ship_w_p - 1
                && int'(bullet_y_i) >= row_top(i, yoff_q)
                && int'(bullet_y_i) <= row_top(i, yoff_q) + ship_h_p - 1) begin
                hit_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (dir_right_i) begin
            edge_w = (int'(x_q) + ship_w_p - 1 + step_p) > x_max_p;
        end else begin
            edge_w = int'(x_q) < step_p;
        end
    end

    // March and drop. A drop requested on the frame itself is honoured at once;
    // at an edge x simply holds until the swarm asks for a drop.
    always_comb begin
        alive_d     = alive_q & ~hit_vec;
        hit_d       = |hit_vec;
        x_d         = x_q;
        yoff_d      = yoff_q;
        drop_pend_d = drop_pend_q | drop_i;
        moving      = frame_i && (state_q != DEAD) && (state_q != LANDED);
        if (moving) begin
            if (drop_pend_q || drop_i) begin
                yoff_d      = coord_t'(int'(yoff_q) + drop_p);
                drop_pend_d = 1'b0;
            end else if (!edge_w) begin
                if (dir_right_i) begin
                    x_d = coord_t'(int'(x_q) + step_p);
                end else begin
                    x_d = coord_t'(int'(x_q) - step_p);
                end
            end
        end
        land_d = cur_any && (int'(row_bottom(cur_idx, yoff_d)) >= land_y_p);
    end

    // Fire pacing. LANDED and DEAD are absorbing and preempt everything;
    // LANDED is tested first so it wins a same-cycle tie.
    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        case (state_q)
            COOL: begin
                if (frame_i) begin
                    if (cool_q == cool_w_p'(fire_delay_p - 1)) begin
                        state_d = FIRE;
                        cool_d  = '0;
                    end else begin
                        cool_d = cool_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                if (fire_ready_i) begin
                    state_d = COOL;
                end
            end
            default: ;
        endcase
        if (state_q != LANDED && state_q != DEAD) begin
            if (land_d) begin
                state_d = LANDED;
            end else if (!nxt_any) begin
                state_d = DEAD;
            end
        end
    end

    // Shot coords freeze while a request is outstanding so the consumer sees
    // a stable origin; only a hit (shooter may have changed) reloads them.
    always_comb begin
        fire_x_d = fire_x_q;
        fire_y_d = fire_y_q;
        if (!(state_q == FIRE && state_d == FIRE) || hit_d) begin
            fire_x_d = coord_t'(int'(x_d) + ship_w_p / 2);
            fire_y_d = coord_t'(int'(row_bottom(nxt_idx, yoff_d)) + 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= COOL;
            x_q         <= coord_t'(left_start_p);
            yoff_q      <= '0;
            alive_q     <= '1;
            cool_q      <= '0;
            drop_pend_q <= 1'b0;
            hit_q       <= 1'b0;
            fire_x_q    <= coord_t'(left_start_p + ship_w_p / 2);
            fire_y_q    <= coord_t'(top_start_p + (rows_p - 1) * row_pitch_p + ship_h_p);
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            yoff_q      <= yoff_d;
            alive_q     <= alive_d;
            cool_q      <= cool_d;
            drop_pend_q <= drop_pend_d;
            hit_q       <= hit_d;
            fire_x_q    <= fire_x_d;
            fire_y_q    <= fire_y_d;
        end
    end

    assign hit_o       = hit_q;
    assign fire_v_o    = (state_q == FIRE);
    assign fire_x_o    = fire_x_q;
    assign fire_y_o    = fire_y_q;
    assign alive_o     = alive_q;
    assign left_pos_o  = x_q;
    assign right_pos_o = coord_t'(int'(x_q) + ship_w_p - 1);
    assign bot_pos_o   = cur_any ? row_bottom(cur_idx, yoff_q) : '0;
    assign edge_o      = edge_w;
    assign landed_o    = (state_q == LANDED);
    assign all_dead_o  = !cur_any;

endmodule

// File: tb/tb_enemy_column_ctrl.sv
// tb_enemy_column_ctrl
// Scenario bench for enemy_column_ctrl (rows_p=5, fire_delay_p=3). Each task
// pushes its expected results when it drives stimulus and pops them when the
// DUT output is due.
module tb_enemy_column_ctrl;
    import enemy_pkg::*;

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic       frame_i = 1'b0;
    logic       dir_right_i = 1'b0;
    logic       drop_i = 1'b0;
    logic       bullet_v_i = 1'b0;
    logic [9:0] bullet_x_i = '0;
    logic [9:0] bullet_y_i = '0;
    logic       fire_ready_i = 1'b0;
    logic       hit_o, fire_v_o, edge_o, landed_o, all_dead_o;
    logic [9:0] fire_x_o, fire_y_o, left_pos_o, right_pos_o, bot_pos_o;
    logic [4:0] alive_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;

    enemy_column_ctrl #(.rows_p(5), .fire_delay_p(3)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .frame_i      (frame_i),
        .dir_right_i  (dir_right_i),
        .drop_i       (drop_i),
        .bullet_v_i   (bullet_v_i),
        .bullet_x_i   (bullet_x_i),
        .bullet_y_i   (bullet_y_i),
        .hit_o        (hit_o),
        .fire_v_o     (fire_v_o),
        .fire_ready_i (fire_ready_i),
        .fire_x_o     (fire_x_o),
        .fire_y_o     (fire_y_o),
        .alive_o      (alive_o),
        .left_pos_o   (left_pos_o),
        .right_pos_o  (right_pos_o),
        .bot_pos_o    (bot_pos_o),
        .edge_o       (edge_o),
        .landed_o     (landed_o),
        .all_dead_o   (all_dead_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0; frame_i = 1'b0; drop_i = 1'b0; bullet_v_i = 1'b0;
        fire_ready_i = 1'b0; dir_right_i = 1'b0;
        tick();
        reset_ni = 1'b1;
    endtask

    task automatic pulse_frame();
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
        tick();
    endtask

    task automatic shoot(input int x, input int y, input logic with_frame);
        bullet_v_i = 1'b1; bullet_x_i = 10'(x); bullet_y_i = 10'(y); frame_i = with_frame;
        tick();
        bullet_v_i = 1'b0; frame_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back({24'd0, 5'h1f, 10'd9, 10'd32, 10'd184, 5'b00000});
        exp_q.push_back({44'd0, 10'd21, 10'd185});
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({24'd0, alive_o, left_pos_o, right_pos_o, bot_pos_o, fire_v_o, hit_o, landed_o, all_dead_o, edge_o} !== exp_v) begin
            errors++; $display("[TB] FAIL reset_state got %h want %h", {alive_o, left_pos_o, right_pos_o, bot_pos_o, fire_v_o, hit_o, landed_o, all_dead_o, edge_o}, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({44'd0, fire_x_o, fire_y_o} !== exp_v) begin
            errors++; $display("[TB] FAIL reset_fire_xy got %0d/%0d want %0d/%0d", fire_x_o, fire_y_o, exp_v[19:10], exp_v[9:0]);
        end
    endtask

    task automatic test_march();
        do_reset();
        dir_right_i = 1'b1;
        exp_q.push_back(64'd29);
        for (int i = 0; i < 10; i++) pulse_frame();
        exp_v = exp_q.pop_front(); checks++;
        if (64'(left_pos_o) !== exp_v) begin
            errors++; $display("[TB] FAIL march_right got %0d want %0d", left_pos_o, exp_v);
        end
        // drop coincident with frame
        exp_q.push_back({44'd0, 10'd192, 10'd29});
        drop_i = 1'b1; frame_i = 1'b1; tick(); drop_i = 1'b0; frame_i = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if ({44'd0, bot_pos_o, left_pos_o} !== exp_v) begin
            errors++; $display("[TB] FAIL drop_with_frame got bot %0d x %0d want bot %0d x %0d", bot_pos_o, left_pos_o, exp_v[19:10], exp_v[9:0]);
        end
        // drop latched ahead of the frame
        drop_i = 1'b1; tick(); drop_i = 1'b0; tick();
        exp_q.push_back({44'd0, 10'd192, 10'd29});
        exp_v = exp_q.pop_front(); checks++;
        if ({44'd0, bot_pos_o, left_pos_o} !== exp_v) begin
            errors++; $display("[TB] FAIL drop_waits_frame got bot %0d x %0d want bot %0d x %0d", bot_pos_o, left_pos_o, exp_v[19:10], exp_v[9:0]);
        end
        exp_q.push_back({44'd0, 10'd200, 10'd29});
        pulse_frame();
        exp_v = exp_q.pop_front(); checks++;
        if ({44'd0, bot_pos_o, left_pos_o} !== exp_v) begin
            errors++; $display("[TB] FAIL drop_pending got bot %0d x %0d want bot %0d x %0d", bot_pos_o, left_pos_o, exp_v[19:10], exp_v[9:0]);
        end
        // march left into the screen edge: 29 -> 1, then hold
        dir_right_i = 1'b0;
        exp_q.push_back({53'd0, 10'd1, 1'b1});
        for (int i = 0; i < 16; i++) pulse_frame();
        exp_v = exp_q.pop_front(); checks++;
        if ({53'd0, left_pos_o, edge_o} !== exp_v) begin
            errors++; $display("[TB] FAIL left_edge_hold got x %0d edge %0b want x %0d edge %0b", left_pos_o, edge_o, exp_v[10:1], exp_v[0]);
        end
    endtask

    task automatic test_hit();
        do_reset();
        exp_q.push_back({58'd0, 1'b0, 5'h1f});
        shoot(33, 24, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if ({58'd0, hit_o, alive_o} !== exp_v) begin
            errors++; $display("[TB] FAIL miss_right_of_box got %b want %b", {hit_o, alive_o}, exp_v[5:0]);
        end
        exp_q.push_back({58'd0, 1'b1, 5'h1e});
        shoot(32, 24, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if ({58'd0, hit_o, alive_o} !== exp_v) begin
            errors++; $display("[TB] FAIL hit_corner_row0 got %b want %b", {hit_o, alive_o}, exp_v[5:0]);
        end
        exp_q.push_back({33'd0, 1'b1, 5'h0e, 10'd144, 10'd145});
        shoot(20, 180, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if ({33'd0, hit_o, alive_o, bot_pos_o, fire_y_o} !== exp_v) begin
            errors++; $display("[TB] FAIL hit_row4 got hit %b alive %b bot %0d fy %0d want %h", hit_o, alive_o, bot_pos_o, fire_y_o, exp_v);
        end
        exp_q.push_back(64'd0);
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (64'(hit_o) !== exp_v) begin
            errors++; $display("[TB] FAIL hit_one_cycle got %b want %b", hit_o, exp_v[0]);
        end
        exp_q.push_back({58'd0, 1'b0, 5'h0e});
        shoot(20, 180, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if ({58'd0, hit_o, alive_o} !== exp_v) begin
            errors++; $display("[TB] FAIL dead_row_transparent got %b want %b", {hit_o, alive_o}, exp_v[5:0]);
        end
        // x=9 is only inside the pre-move box
        dir_right_i = 1'b1;
        exp_q.push_back({48'd0, 1'b1, 5'h0c, 10'd11});
        shoot(9, 60, 1'b1);
        exp_v = exp_q.pop_front(); checks++;
        if ({48'd0, hit_o, alive_o, left_pos_o} !== exp_v) begin
            errors++; $display("[TB] FAIL hit_pre_move got hit %b alive %b x %0d want %h", hit_o, alive_o, left_pos_o, exp_v);
        end
    endtask

    task automatic test_fire();
        do_reset();
        dir_right_i = 1'b1;
        exp_q.push_back(64'd0);
        pulse_frame(); pulse_frame();
        exp_v = exp_q.pop_front(); checks++;
        if (64'(fire_v_o) !== exp_v) begin
            errors++; $display("[TB] FAIL fire_early got %b want %b", fire_v_o, exp_v[0]);
        end
        frame_i = 1'b1; tick(); frame_i = 1'b0;
        for (int c = 0; c < 20; c++) exp_q.push_back({43'd0, 1'b1, 10'd27, 10'd185});
        for (int c = 0; c < 20; c++) begin
            exp_v = exp_q.pop_front(); checks++;
            if ({43'd0, fire_v_o, fire_x_o, fire_y_o} !== exp_v) begin
                errors++; $display("[TB] FAIL fire_hold c%0d got v %b x %0d y %0d want %h", c, fire_v_o, fire_x_o, fire_y_o, exp_v);
            end
            tick();
        end
        fire_ready_i = 1'b1; tick(); fire_ready_i = 1'b0;
        exp_q.push_back(64'd0);
        exp_v = exp_q.pop_front(); checks++;
        if (64'(fire_v_o) !== exp_v) begin
            errors++; $display("[TB] FAIL fire_accept got %b want %b", fire_v_o, exp_v[0]);
        end
        exp_q.push_back(64'd0);
        pulse_frame(); pulse_frame();
        exp_v = exp_q.pop_front(); checks++;
        if (64'(fire_v_o) !== exp_v) begin
            errors++; $display("[TB] FAIL refire_early got %b want %b", fire_v_o, exp_v[0]);
        end
        exp_q.push_back({43'd0, 1'b1, 10'd33, 10'd185});
        frame_i = 1'b1; tick(); frame_i = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if ({43'd0, fire_v_o, fire_x_o, fire_y_o} !== exp_v) begin
            errors++; $display("[TB] FAIL refire_third_frame got v %b x %0d y %0d want %h", fire_v_o, fire_x_o, fire_y_o, exp_v);
        end
        exp_q.push_back({43'd0, 1'b1, 10'd33, 10'd145});
        shoot(30, 175, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if ({43'd0, fire_v_o, fire_x_o, fire_y_o} !== exp_v) begin
            errors++; $display("[TB] FAIL shooter_hit_in_fire got v %b x %0d y %0d want %h", fire_v_o, fire_x_o, fire_y_o, exp_v);
        end
        exp_q.push_back({58'd0, 1'b0, 5'h1f});
        reset_ni = 1'b0; tick(); reset_ni = 1'b1;
        exp_v = exp_q.pop_front(); checks++;
        if ({58'd0, fire_v_o, alive_o} !== exp_v) begin
            errors++; $display("[TB] FAIL reset_in_fire got %b want %b", {fire_v_o, alive_o}, exp_v[5:0]);
        end
    endtask

    task automatic test_kill_all();
        do_reset();
        dir_right_i = 1'b1;
        pulse_frame(); pulse_frame(); pulse_frame();
        for (int r = 4; r >= 1; r--) begin
            shoot(20, 9 + 40 * r + 5, 1'b0);
            exp_q.push_back({57'd0, 1'b1, 1'b0, 5'(5'h1f >> (5 - r))});
            exp_v = exp_q.pop_front(); checks++;
            if ({57'd0, fire_v_o, all_dead_o, alive_o} !== exp_v) begin
                errors++; $display("[TB] FAIL kill_row%0d got %b want %b", r, {fire_v_o, all_dead_o, alive_o}, exp_v[6:0]);
            end
        end
        exp_q.push_back({44'd0, 1'b0, 1'b1, 5'h00, 3'd0, 10'd0});
        shoot(20, 14, 1'b0);
        exp_v = exp_q.pop_front(); checks++;
        if ({44'd0, fire_v_o, all_dead_o, alive_o, 3'd0, bot_pos_o} !== exp_v) begin
            errors++; $display("[TB] FAIL kill_last got v %b dead %b alive %b bot %0d want %h", fire_v_o, all_dead_o, alive_o, bot_pos_o, exp_v);
        end
        exp_q.push_back(64'd15);
        pulse_frame(); pulse_frame();
        exp_v = exp_q.pop_front(); checks++;
        if (64'(left_pos_o) !== exp_v) begin
            errors++; $display("[TB] FAIL dead_no_move got %0d want %0d", left_pos_o, exp_v);
        end
    endtask

    task automatic test_landing();
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            exp_q.push_back({53'd0, 10'(184 + 8 * k), (k == 32)});
            drop_i = 1'b1; frame_i = 1'b1; tick(); drop_i = 1'b0; frame_i = 1'b0;
            exp_v = exp_q.pop_front();
            if (k >= 30) begin
                checks++;
                if ({53'd0, bot_pos_o, landed_o} !== exp_v) begin
                    errors++; $display("[TB] FAIL land_drop%0d got bot %0d landed %b want bot %0d landed %b", k, bot_pos_o, landed_o, exp_v[10:1], exp_v[0]);
                end
            end
        end
        dir_right_i = 1'b1;
        exp_q.push_back({42'd0, 10'd9, 10'd440, 1'b1, 1'b0});
        pulse_frame(); drop_i = 1'b1; pulse_frame(); drop_i = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if ({42'd0, left_pos_o, bot_pos_o, landed_o, fire_v_o} !== exp_v) begin
            errors++; $display("[TB] FAIL landed_frozen got x %0d bot %0d landed %b v %b want %h", left_pos_o, bot_pos_o, landed_o, fire_v_o, exp_v);
        end
        exp_q.push_back({35'd0, 5'h1f, 10'd9, 10'd184, 1'b0, 1'b0, 1'b0});
        reset_ni = 1'b0; tick(); reset_ni = 1'b1;
        exp_v = exp_q.pop_front(); checks++;
        if ({35'd0, alive_o, left_pos_o, bot_pos_o, landed_o, fire_v_o, all_dead_o} !== exp_v) begin
            errors++; $display("[TB] FAIL landed_reset got %h want %h", {alive_o, left_pos_o, bot_pos_o, landed_o, fire_v_o, all_dead_o}, exp_v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_march();
        test_hit();
        test_fire();
        test_kill_all();
        test_landing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
